// File: rtl/ram_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_reader_pkg
// Description : Shared types and constants for the RAM stream reader.
//               - state_e           : reader FSM states
//               - RAM_LATENCY_LOW   : low-latency RAM mode (1 cycle)
//               - RAM_LATENCY_HIGH  : high-performance RAM mode (2 cycles)
//               - fifo_depth()      : response FIFO depth for a RAM latency
// Revision    : 1.0 - initial release
// ============================================================================
package ram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int RAM_LATENCY_LOW  = 1;
    localparam int RAM_LATENCY_HIGH = 2;

    // Enough room for every in-flight read plus two buffered words, which is
    // what lets the reader keep one word per cycle flowing with no bubbles.
    function automatic int fifo_depth(input int ram_latency);
        return ram_latency + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ram_reader_fifo
// Description : Small first-word-fall-through FIFO with occupancy count.
//               The head entry is visible on o_rdata whenever o_empty is low.
// Ports       : i_clk, i_a_rst_n (async, active-low)
//               i_push / i_wdata   - write side (ignored when full, no pop)
//               i_pop              - consume head (ignored when empty)
//               o_rdata            - head entry
//               o_empty, o_count   - status
// Revision    : 1.0 - initial release
// ============================================================================
module ram_reader_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_a_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign do_pop  = i_pop && (count_q != '0);
    assign do_push = i_push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed once written.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_wdata;
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_reader
// Description : Read master for one dual-port RAM port. On i_start it reads
//               i_length consecutive words from i_base_addr (wrapping at the
//               top of the address space) and streams them out in order on a
//               valid/ready interface. Reads are only issued while the
//               response FIFO is guaranteed room for them, so backpressure
//               never loses a word.
// Ports       : i_clk, i_a_rst_n (async, active-low)
//               i_start, i_base_addr, i_length  - run command (IDLE only)
//               o_busy, o_done                  - status / completion pulse
//               o_ram_wr_en, o_ram_addr, i_ram_data - RAM read port
//               o_valid, o_data, i_ready        - output stream
//               o_last                          - final word marker
// Config      : RAM_READER_LAST_EN - when defined, adds o_last.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_reader
    import ram_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int RAM_LATENCY = 2
) (
    input  logic                  i_clk,
    input  logic                  i_a_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_length,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ram_wr_en,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready
`ifdef RAM_READER_LAST_EN
    ,
    output logic                  o_last
`endif
);
    localparam int FIFO_DEPTH = fifo_depth(RAM_LATENCY);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
`ifdef RAM_READER_LAST_EN
    localparam int FIFO_W     = DATA_WIDTH + 1;
`else
    localparam int FIFO_W     = DATA_WIDTH;
`endif

    if ((RAM_LATENCY != RAM_LATENCY_LOW) && (RAM_LATENCY != RAM_LATENCY_HIGH)) begin : g_bad_latency
        $error("ram_stream_reader: RAM_LATENCY must be 1 or 2");
    end

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     remaining_q;
    logic                    busy_q;
    logic                    done_q;
    logic [RAM_LATENCY-1:0]  tags_q;       // one bit per in-flight read

    logic [CNT_W-1:0]        outstanding;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W:0]          occupancy;
    logic                    fifo_empty;
    logic                    issue;
    logic                    is_last_issue;
    logic                    pop;
    logic                    drain_done;
    logic [FIFO_W-1:0]       fifo_wdata;
    logic [FIFO_W-1:0]       fifo_rdata;

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            outstanding = outstanding + CNT_W'(tags_q[i]);
        end
    end

    // Every word already in the FIFO or still in flight owns a FIFO slot, so
    // a read may only go out while at least one slot is unclaimed.
    assign occupancy     = {1'b0, fifo_count} + {1'b0, outstanding};
    assign issue         = (state_q == ISSUE) && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign is_last_issue = (remaining_q == (ADDR_WIDTH + 1)'(1));
    assign pop           = o_valid && i_ready;
    // Final word may still be sitting at the head; leave only once it is taken.
    assign drain_done    = (outstanding == '0) &&
                           ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        busy_q <= 1'b1;
                        if (i_length != '0) begin
                            addr_q      <= i_base_addr;
                            remaining_q <= i_length;
                            state_q     <= ISSUE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr_q      <= addr_q + ADDR_WIDTH'(1);
                        remaining_q <= remaining_q - (ADDR_WIDTH + 1)'(1);
                        if (is_last_issue) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag pipeline mirrors the RAM read latency; the tail bit marks the
    // cycle in which i_ram_data belongs to one of our reads.
    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            tags_q <= '0;
        end else begin
            for (int i = RAM_LATENCY - 1; i > 0; i--) begin
                tags_q[i] <= tags_q[i-1];
            end
            tags_q[0] <= issue;
        end
    end

`ifdef RAM_READER_LAST_EN
    logic [RAM_LATENCY-1:0] last_tags_q;

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            last_tags_q <= '0;
        end else begin
            for (int i = RAM_LATENCY - 1; i > 0; i--) begin
                last_tags_q[i] <= last_tags_q[i-1];
            end
            last_tags_q[0] <= issue && is_last_issue;
        end
    end

    assign fifo_wdata = {last_tags_q[RAM_LATENCY-1], i_ram_data};
    assign o_data     = fifo_rdata[DATA_WIDTH-1:0];
    // Gated so a stale marker left in storage by a reset is never visible.
    assign o_last     = o_valid && fifo_rdata[DATA_WIDTH];
`else
    assign fifo_wdata = i_ram_data;
    assign o_data     = fifo_rdata;
`endif

    ram_reader_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_a_rst_n (i_a_rst_n),
        .i_push    (tags_q[RAM_LATENCY-1]),
        .i_wdata   (fifo_wdata),
        .i_pop     (pop),
        .o_rdata   (fifo_rdata),
        .o_empty   (fifo_empty),
        .o_count   (fifo_count)
    );

    assign o_valid     = !fifo_empty;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_ram_addr  = addr_q;
    assign o_ram_wr_en = 1'b0;

endmodule
`default_nettype wire
